aes_block_packer: RTL and testbench

//  Engine-side datapath between the plaintext/ciphertext HWPE streams and the AES core.

---
 rtl/aes_block_packer_pkg.sv | 23 ++
 rtl/aes_block_packer_word_sreg.sv | 55 +++++
 rtl/aes_block_packer.sv | 154 +++++++++++++++
 tb/tb_aes_block_packer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_block_packer_pkg.sv
// Shared constants and FSM state type for the AES block packer.
// Contents:
//   AES_WORD_W / AES_BLOCK_W / AES_WPB  stream word width, AES block width, words per block
//   AES_IDX_W                           width of the word index inside a block
//   AES_NBLK_W                          width of the per-job block count
//   aes_packer_state_t                  packer sequencing states
package aes_block_packer_pkg;

  localparam int AES_WORD_W  = 32;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_WPB     = AES_BLOCK_W / AES_WORD_W;
  localparam int AES_IDX_W   = 2;
  localparam int AES_NBLK_W  = 16;

  typedef enum logic [2:0] {
    PK_IDLE,
    PK_FILL,
    PK_ISSUE,
    PK_WAIT,
    PK_DRAIN
  } aes_packer_state_t;

endpackage

// File: rtl/aes_block_packer_word_sreg.sv
// aes_word_sreg: BLOCK_W-wide word shift register with a word index.
// Used both to pack words into a block (shift words in at the LSW end, so the
// first word ends up as the MSW) and to unpack a block (parallel load, then
// shift left so the MSW is always the word being presented).
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   clr        in   synchronous soft clear (same effect as rst)
//   load       in   parallel load of load_data; index returns to 0
//   load_data  in   BLOCK_W block to load
//   shift      in   shift left by one word, word_in enters at the LSW; index advances
//   word_in    in   WORD_W word shifted in
//   block      out  current register contents
//   last       out  index points at the final word of the block
module aes_word_sreg
  import aes_block_packer_pkg::*;
#(
  parameter int WORD_W  = AES_WORD_W,
  parameter int BLOCK_W = AES_BLOCK_W,
  parameter int IDX_W   = AES_IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic [BLOCK_W-1:0] load_data,
  input  logic               shift,
  input  logic [WORD_W-1:0]  word_in,
  output logic [BLOCK_W-1:0] block,
  output logic               last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_W / WORD_W - 1);

  logic [BLOCK_W-1:0] data;
  logic [IDX_W-1:0]   idx;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      data <= '0;
      idx  <= '0;
    end else if (load) begin
      data <= load_data;
      idx  <= '0;
    end else if (shift) begin
      data <= {data[BLOCK_W-WORD_W-1:0], word_in};
      // Index is exactly as wide as the word count, so it wraps to 0 at each block boundary.
      idx  <= idx + IDX_W'(1);
    end
  end

  assign block = data;
  assign last  = (idx == LAST_IDX);

endmodule

// File: rtl/aes_block_packer.sv
// aes_block_packer: engine-side datapath between the HWPE plaintext/ciphertext
// streams and the AES core. Packs four 32-bit plaintext words (first word = MSW)
// into a 128-bit block, offers it to the core, latches the core result and
// unpacks it MSW-first onto the ciphertext stream. One block in flight at a time.
// Ports:
//   clk, reset, clear_i           clock, sync active-high reset, sync soft clear
//   start_i, n_blocks_i           job start (honoured in IDLE) and block count
//   in_data_i/in_valid_i/in_ready_o              plaintext word stream
//   core_block_o/core_valid_o/core_ready_i       block to AES core
//   core_res_i/core_res_valid_i/core_res_ready_o result from AES core
//   out_data_o/out_valid_o/out_ready_i           ciphertext word stream
//   blk_cnt_o                     blocks fully drained in the current job
//   busy_o                        high whenever not IDLE
//   done_o                        one-cycle pulse at job end
module aes_block_packer
  import aes_block_packer_pkg::*;
#(
  parameter int WORD_W  = AES_WORD_W,
  parameter int BLOCK_W = AES_BLOCK_W,
  parameter int NBLK_W  = AES_NBLK_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               start_i,
  input  logic [NBLK_W-1:0]  n_blocks_i,
  input  logic [WORD_W-1:0]  in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [BLOCK_W-1:0] core_block_o,
  output logic               core_valid_o,
  input  logic               core_ready_i,
  input  logic [BLOCK_W-1:0] core_res_i,
  input  logic               core_res_valid_i,
  output logic               core_res_ready_o,
  output logic [WORD_W-1:0]  out_data_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [NBLK_W-1:0]  blk_cnt_o,
  output logic               busy_o,
  output logic               done_o
);

  aes_packer_state_t state_q, state_d;

  logic [NBLK_W-1:0]  n_blocks_q;
  logic [NBLK_W-1:0]  blk_cnt_q;
  logic [NBLK_W-1:0]  blk_cnt_inc;
  logic               done_q, done_d;
  logic               start_ok;
  logic               in_hs, res_hs, out_hs;
  logic               pack_last, unpack_last;
  logic               blk_done;
  logic [BLOCK_W-1:0] unpack_block;

  assign in_hs       = in_valid_i & in_ready_o;
  assign res_hs      = core_res_valid_i & core_res_ready_o;
  assign out_hs      = out_valid_o & out_ready_i;
  assign start_ok    = (state_q == PK_IDLE) & start_i;
  assign blk_done    = out_hs & unpack_last;
  assign blk_cnt_inc = blk_cnt_q + NBLK_W'(1);

  aes_word_sreg #(.WORD_W(WORD_W), .BLOCK_W(BLOCK_W), .IDX_W(AES_IDX_W)) u_pack (
    .clk       (clk),
    .rst       (reset),
    .clr       (clear_i),
    .load      (1'b0),
    .load_data ('0),
    .shift     (in_hs),
    .word_in   (in_data_i),
    .block     (core_block_o),
    .last      (pack_last)
  );

  // The unpack register shifts zeros in behind the departing words.
  aes_word_sreg #(.WORD_W(WORD_W), .BLOCK_W(BLOCK_W), .IDX_W(AES_IDX_W)) u_unpack (
    .clk       (clk),
    .rst       (reset),
    .clr       (clear_i),
    .load      (res_hs),
    .load_data (core_res_i),
    .shift     (out_hs),
    .word_in   ('0),
    .block     (unpack_block),
    .last      (unpack_last)
  );

  assign out_data_o = unpack_block[BLOCK_W-1 -: WORD_W];

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      state_q    <= PK_IDLE;
      n_blocks_q <= '0;
      blk_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (start_ok) begin
        n_blocks_q <= n_blocks_i;
        blk_cnt_q  <= '0;
      end else if (blk_done) begin
        blk_cnt_q <= blk_cnt_inc;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    done_d           = 1'b0;
    in_ready_o       = 1'b0;
    core_valid_o     = 1'b0;
    core_res_ready_o = 1'b0;
    out_valid_o      = 1'b0;
    case (state_q)
      PK_IDLE: begin
        if (start_i) begin
          // An empty job completes immediately without leaving IDLE.
          if (n_blocks_i == '0) done_d  = 1'b1;
          else                  state_d = PK_FILL;
        end
      end
      PK_FILL: begin
        in_ready_o = 1'b1;
        if (in_hs && pack_last) state_d = PK_ISSUE;
      end
      PK_ISSUE: begin
        core_valid_o = 1'b1;
        if (core_ready_i) state_d = PK_WAIT;
      end
      PK_WAIT: begin
        core_res_ready_o = 1'b1;
        if (core_res_valid_i) state_d = PK_DRAIN;
      end
      PK_DRAIN: begin
        out_valid_o = 1'b1;
        if (out_ready_i && unpack_last) begin
          if (blk_cnt_inc == n_blocks_q) begin
            state_d = PK_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = PK_FILL;
          end
        end
      end
      default: state_d = PK_IDLE;
    endcase
  end

  assign blk_cnt_o = blk_cnt_q;
  assign busy_o    = (state_q != PK_IDLE);
  assign done_o    = done_q;

endmodule

// File: tb/tb_aes_block_packer.sv
// Testbench for aes_block_packer: directed jobs with a scoreboard model of the
// expected blocks, ciphertext words, block count, busy and done, plus literal
// expectations for the hand-computed cases.
module tb_aes_block_packer;

  logic         clk;
  logic         reset;
  logic         clear_i;
  logic         start_i;
  logic [15:0]  n_blocks_i;
  logic [31:0]  in_data_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] core_block_o;
  logic         core_valid_o;
  logic         core_ready_i;
  logic [127:0] core_res_i;
  logic         core_res_valid_i;
  logic         core_res_ready_o;
  logic [31:0]  out_data_o;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [15:0]  blk_cnt_o;
  logic         busy_o;
  logic         done_o;

  aes_block_packer dut (
    .clk              (clk),
    .reset            (reset),
    .clear_i          (clear_i),
    .start_i          (start_i),
    .n_blocks_i       (n_blocks_i),
    .in_data_i        (in_data_i),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .core_block_o     (core_block_o),
    .core_valid_o     (core_valid_o),
    .core_ready_i     (core_ready_i),
    .core_res_i       (core_res_i),
    .core_res_valid_i (core_res_valid_i),
    .core_res_ready_o (core_res_ready_o),
    .out_data_o       (out_data_o),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .blk_cnt_o        (blk_cnt_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Stimulus / core-model controls
  logic [31:0]  src_q[$];
  int           src_gap  = 0;
  int           sink_gap = 0;
  int           core_gap = 0;
  int           core_lat = 1;
  logic [127:0] mask     = '0;
  bit           hold_req = 0;
  int           hold_left = 0;
  bit           core_has = 0;
  int           core_cnt = 0;
  logic [127:0] core_hold;

  // Handshakes seen at the negedge, i.e. those taking effect on the next posedge
  bit           hs_in, hs_core, hs_res, hs_out;
  logic [127:0] hs_core_blk;

  // Scoreboard model
  bit           en_chk     = 0;
  bit           job_active = 0;
  int           n_job      = 0;
  int           beats      = 0;
  int           blk_exp    = 0;
  bit           done_exp   = 0;
  int           wc         = 0;
  logic [127:0] acc        = '0;
  logic [31:0]  exp_out[$];
  logic [127:0] exp_blk[$];
  bit           prev_ov    = 0;
  logic [31:0]  prev_od    = '0;

  // Observations for literal checks
  int           done_cnt      = 0;
  int           in_ready_seen = 0;
  int           busy_seen     = 0;
  bit           seen_wait     = 0;
  logic [31:0]  got_out[$];
  logic [127:0] last_core_block = '0;

  always @(negedge clk) begin
    hs_in   = (in_valid_i & in_ready_o) === 1'b1;
    hs_core = (core_valid_o & core_ready_i) === 1'b1;
    hs_res  = (core_res_valid_i & core_res_ready_o) === 1'b1;
    hs_out  = (out_valid_o & out_ready_i) === 1'b1;
    hs_core_blk = core_block_o;
    if (en_chk) begin
      chk("done_o", {127'd0, done_o}, {127'd0, done_exp});
      chk("blk_cnt_o", {112'd0, blk_cnt_o}, 128'(blk_exp));
      chk("busy_o", {127'd0, busy_o}, {127'd0, job_active});
      if (!job_active) begin
        chk("in_ready_idle", {127'd0, in_ready_o}, '0);
        chk("out_valid_idle", {127'd0, out_valid_o}, '0);
      end
      if (prev_ov) begin
        chk("out_hold_valid", {127'd0, out_valid_o}, 128'd1);
        chk("out_hold_data", {96'd0, out_data_o}, {96'd0, prev_od});
      end
      if (done_o === 1'b1) done_cnt++;
      if (in_ready_o === 1'b1) in_ready_seen++;
      if (busy_o === 1'b1) busy_seen++;
      if (core_res_ready_o === 1'b1) seen_wait = 1;

      if (reset || clear_i) begin
        job_active = 0;
        blk_exp    = 0;
        done_exp   = 0;
        beats      = 0;
        wc         = 0;
        acc        = '0;
        exp_out.delete();
        exp_blk.delete();
      end else begin
        done_exp = 0;
        if (!job_active && start_i) begin
          blk_exp = 0;
          beats   = 0;
          if (n_blocks_i == 16'd0) done_exp = 1;
          else begin
            job_active = 1;
            n_job      = int'(n_blocks_i);
          end
        end
        if (hs_in) begin
          acc[127-32*wc -: 32] = in_data_i;
          exp_out.push_back(in_data_i ^ mask[127-32*wc -: 32]);
          wc = (wc + 1) % 4;
          if (wc == 0) exp_blk.push_back(acc);
        end
        if (hs_core) begin
          last_core_block = core_block_o;
          if (exp_blk.size() > 0) chk("core_block", core_block_o, exp_blk.pop_front());
          else begin
            checks++; failures++;
            $display("FAIL core_block unexpected block actual=%h", core_block_o);
          end
        end
        if (hs_out) begin
          got_out.push_back(out_data_o);
          if (exp_out.size() > 0) chk("out_data", {96'd0, out_data_o}, {96'd0, exp_out.pop_front()});
          else begin
            checks++; failures++;
            $display("FAIL out_data unexpected word actual=%h", out_data_o);
          end
          beats++;
          if (beats % 4 == 0) begin
            blk_exp++;
            if (blk_exp == n_job) begin
              job_active = 0;
              done_exp   = 1;
            end
          end
        end
      end
      prev_ov = (out_valid_o === 1'b1) && !hs_out && !(reset || clear_i);
      prev_od = out_data_o;
    end
  end

  // Source, AES-core and sink agents, driven just after each rising edge
  always @(posedge clk) begin
    #1;
    if (reset) begin
      in_valid_i       = 0;
      core_ready_i     = 0;
      core_res_valid_i = 0;
      out_ready_i      = 0;
      core_has         = 0;
    end else begin
      if (hs_in) in_valid_i = 0;
      if (!in_valid_i && src_q.size() > 0 && int'($urandom_range(99)) >= src_gap) begin
        in_data_i  = src_q.pop_front();
        in_valid_i = 1;
      end
      if (hs_res) core_res_valid_i = 0;
      if (hs_core) begin
        core_has  = 1;
        core_hold = hs_core_blk ^ mask;
        core_cnt  = core_lat;
      end
      if (core_has && !core_res_valid_i) begin
        if (core_cnt <= 1) begin
          core_res_i       = core_hold;
          core_res_valid_i = 1;
          core_has         = 0;
        end else core_cnt--;
      end
      core_ready_i = !core_has && !core_res_valid_i && int'($urandom_range(99)) >= core_gap;
      if (hold_left > 0) begin
        out_ready_i = 0;
        hold_left--;
      end else if (hold_req && out_valid_o === 1'b1) begin
        hold_req    = 0;
        hold_left   = 9;
        out_ready_i = 0;
      end else begin
        out_ready_i = int'($urandom_range(99)) >= sink_gap;
      end
    end
  end

  task automatic start_job(input int n);
    @(posedge clk); #1;
    start_i    = 1;
    n_blocks_i = 16'(n);
    @(posedge clk); #1;
    start_i = 0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int k = 0;
    while (done_cnt == d0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (done_cnt == d0) begin
      failures++;
      $display("FAIL %s timeout waiting for done_o after %0d cycles", name, k);
    end
    repeat (3) @(negedge clk);
  endtask

  int d0, ir0, bs0;
  logic [31:0] w1[4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
  logic [31:0] w4[4] = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF};

  initial begin
    reset = 1; clear_i = 0; start_i = 0; n_blocks_i = '0;
    in_data_i = '0; in_valid_i = 0; core_ready_i = 0; core_res_i = '0;
    core_res_valid_i = 0; out_ready_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {127'd0, in_ready_o}, '0);
    chk("rst_core_valid", {127'd0, core_valid_o}, '0);
    chk("rst_core_block", core_block_o, '0);
    chk("rst_core_res_ready", {127'd0, core_res_ready_o}, '0);
    chk("rst_out_valid", {127'd0, out_valid_o}, '0);
    chk("rst_out_data", {96'd0, out_data_o}, '0);
    chk("rst_blk_cnt", {112'd0, blk_cnt_o}, '0);
    chk("rst_busy", {127'd0, busy_o}, '0);
    chk("rst_done", {127'd0, done_o}, '0);
    en_chk = 1;
    @(posedge clk); #1;
    reset = 0;

    // Single block, core echoes its input
    mask = '0;
    for (int i = 0; i < 4; i++) src_q.push_back(w1[i]);
    got_out.delete();
    d0 = done_cnt;
    start_job(1);
    wait_done(d0, "t1_done");
    chk("t1_core_block", last_core_block, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("t1_out_count", 128'(got_out.size()), 128'd4);
    for (int i = 0; i < 4 && i < got_out.size(); i++)
      chk("t1_out_word", {96'd0, got_out[i]}, {96'd0, w1[i]});
    chk("t1_done_once", 128'(done_cnt - d0), 128'd1);
    chk("t1_blk_cnt", {112'd0, blk_cnt_o}, 128'd1);

    // Three blocks with random gaps on every handshake
    mask = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    src_gap = 30; sink_gap = 30; core_gap = 30; core_lat = 3;
    for (int i = 0; i < 12; i++) src_q.push_back(32'h10000000 * i + 32'h00010203 * (i + 1));
    got_out.delete();
    d0 = done_cnt;
    start_job(3);
    wait_done(d0, "t2_done");
    chk("t2_out_count", 128'(got_out.size()), 128'd12);
    chk("t2_done_once", 128'(done_cnt - d0), 128'd1);
    chk("t2_blk_cnt", {112'd0, blk_cnt_o}, 128'd3);
    src_gap = 0; sink_gap = 0; core_gap = 0; core_lat = 1;

    // Empty job
    d0 = done_cnt; ir0 = in_ready_seen; bs0 = busy_seen;
    start_job(0);
    repeat (3) @(negedge clk);
    chk("t3_done_once", 128'(done_cnt - d0), 128'd1);
    chk("t3_no_in_ready", 128'(in_ready_seen - ir0), 128'd0);
    chk("t3_no_busy", 128'(busy_seen - bs0), 128'd0);
    chk("t3_blk_cnt", {112'd0, blk_cnt_o}, 128'd0);

    // Clear after two FILL words (with a simultaneous start), then a fresh job
    mask = '0;
    src_q.push_back(32'h11111111);
    src_q.push_back(32'h22222222);
    d0 = done_cnt;
    start_job(1);
    for (int k = 0; k < 200 && (src_q.size() > 0 || in_valid_i); k++) @(posedge clk);
    @(posedge clk); #1;
    clear_i = 1; start_i = 1; n_blocks_i = 16'd1;
    @(posedge clk); #1;
    clear_i = 0; start_i = 0;
    @(negedge clk);
    chk("t4_busy_after_clear", {127'd0, busy_o}, '0);
    chk("t4_no_done", 128'(done_cnt - d0), 128'd0);
    for (int i = 0; i < 4; i++) src_q.push_back(w4[i]);
    start_job(1);
    wait_done(d0, "t4_done");
    chk("t4_core_block", last_core_block, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);

    // Sink stalls for 10 cycles in DRAIN
    hold_req = 1;
    for (int i = 0; i < 4; i++) src_q.push_back(w1[3-i]);
    got_out.delete();
    d0 = done_cnt;
    start_job(1);
    wait_done(d0, "t5_done");
    chk("t5_out_count", 128'(got_out.size()), 128'd4);
    for (int i = 0; i < 4 && i < got_out.size(); i++)
      chk("t5_out_word", {96'd0, got_out[i]}, {96'd0, w1[3-i]});

    // start_i during WAIT with a different count is ignored
    core_lat = 6;
    for (int i = 0; i < 8; i++) src_q.push_back(32'hF0000000 + i);
    got_out.delete();
    d0 = done_cnt;
    seen_wait = 0;
    start_job(2);
    for (int k = 0; k < 200 && !seen_wait; k++) @(posedge clk);
    chk("t6_reached_wait", {127'd0, seen_wait}, 128'd1);
    @(posedge clk); #1;
    start_i = 1; n_blocks_i = 16'd5;
    @(posedge clk); #1;
    start_i = 0;
    wait_done(d0, "t6_done");
    repeat (10) @(negedge clk);
    chk("t6_blk_cnt", {112'd0, blk_cnt_o}, 128'd2);
    chk("t6_out_count", 128'(got_out.size()), 128'd8);
    chk("t6_done_once", 128'(done_cnt - d0), 128'd1);
    chk("t6_idle", {127'd0, busy_o}, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
